// File: rtl/aux_burst.sv
// =============================================================================
//  Module   : aux_burst
//  Purpose  : Multi-byte AUX transaction sequencer. It splits one host burst
//             into single-byte engine requests, with per-byte retry and a
//             local 2^AW-byte data buffer.
//  Options  : `define AUXB_ABORT_EN adds the 'abort' input.
//  Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module aux_burst #(
    parameter int AW       = 4,
    parameter int MAXRETRY = 7,
    parameter int GAP      = 200
) (
    input  logic          clk,
    input  logic          rst,
`ifdef AUXB_ABORT_EN
    input  logic          abort,
`endif
    input  logic          cmdvalid,
    output logic          cmdready,
    input  logic          cmdwr,
    input  logic [19:0]   cmdaddr,
    input  logic [AW-1:0] cmdlen,
    input  logic          bufwe,
    input  logic [AW-1:0] bufidx,
    input  logic [7:0]    bufwdata,
    output logic [7:0]    bufrdata,
    output logic          done,
    output logic          err,
    output logic [AW:0]   nbytes,
    output logic [19:0]   auxaddr,
    output logic [7:0]    auxwdata,
    output logic          auxreq,
    output logic          auxwr,
    input  logic          auxack,
    input  logic          auxerr,
    input  logic [7:0]    auxrdata
);

    localparam int c_rw    = (MAXRETRY > 0) ? $clog2(MAXRETRY + 1) : 1;
    localparam int c_gw    = (GAP > 1) ? $clog2(GAP) : 1;
    localparam int c_depth = 1 << AW;
    localparam logic [c_rw-1:0] c_maxretry = c_rw'(MAXRETRY);
    localparam logic [c_gw-1:0] c_gap_last = c_gw'(GAP - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_GAP   = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    state_t           r_state;
    logic             r_wr;
    logic [19:0]      r_addr;
    logic [AW-1:0]    r_len;
    logic [AW:0]      r_idx;
    logic [c_rw-1:0]  r_retry;
    logic [c_gw-1:0]  r_gapcnt;
    logic             r_abortpend;
    logic [7:0]       r_mem [c_depth];

    logic             w_accept;
    logic             w_engwe;
    logic             w_hostwe;
    logic             w_we;
    logic [AW-1:0]    w_widx;
    logic [7:0]       w_wdata;
    logic [AW:0]      w_idx_inc;
    logic             w_last;
    logic             w_exhausted;
    logic             w_abort;
    logic [7:0]       w_mem0;

`ifdef AUXB_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    assign w_accept    = cmdvalid && cmdready;
    assign w_engwe     = (r_state == S_ISSUE) && auxack && !auxerr && !r_wr;
    assign w_hostwe    = bufwe && cmdready;
    assign w_we        = w_engwe || w_hostwe;
    assign w_widx      = w_engwe ? r_idx[AW-1:0] : bufidx;
    assign w_wdata     = w_engwe ? auxrdata : bufwdata;
    assign w_idx_inc   = r_idx + 1'b1;
    assign w_last      = (w_idx_inc == ({1'b0, r_len} + 1'b1));
    assign w_exhausted = auxerr && (r_retry == c_maxretry);
    // A host write to byte 0 in the accept cycle must reach the first request.
    assign w_mem0      = (w_hostwe && (bufidx == '0)) ? bufwdata : r_mem[0];

    assign nbytes = r_idx;

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_widx] <= w_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_wr        <= 1'b0;
            r_addr      <= '0;
            r_len       <= '0;
            r_idx       <= '0;
            r_retry     <= '0;
            r_gapcnt    <= '0;
            r_abortpend <= 1'b0;
            cmdready    <= 1'b1;
            done        <= 1'b0;
            err         <= 1'b0;
            auxreq      <= 1'b0;
            auxwr       <= 1'b0;
            auxaddr     <= '0;
            auxwdata    <= '0;
            bufrdata    <= '0;
        end else begin
            done     <= 1'b0;
            // Write-first: the host sees a byte landing in the same cycle.
            bufrdata <= (w_we && (w_widx == bufidx)) ? w_wdata : r_mem[bufidx];

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_wr        <= cmdwr;
                        r_addr      <= cmdaddr;
                        r_len       <= cmdlen;
                        r_idx       <= '0;
                        r_retry     <= '0;
                        r_abortpend <= 1'b0;
                        err         <= 1'b0;
                        cmdready    <= 1'b0;
                        auxreq      <= 1'b1;
                        auxwr       <= cmdwr;
                        auxaddr     <= cmdaddr;
                        auxwdata    <= w_mem0;
                        r_state     <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    if (w_abort) begin
                        r_abortpend <= 1'b1;
                    end
                    if (auxack) begin
                        auxreq   <= 1'b0;
                        r_gapcnt <= c_gap_last;
                        if (!auxerr) begin
                            r_idx   <= w_idx_inc;
                            r_retry <= '0;
                        end else if (!w_exhausted) begin
                            r_retry <= r_retry + 1'b1;
                        end

                        if (w_exhausted || w_abort || r_abortpend) begin
                            err     <= 1'b1;
                            done    <= 1'b1;
                            r_state <= S_FIN;
                        end else if (!auxerr && w_last) begin
                            done    <= 1'b1;
                            r_state <= S_FIN;
                        end else begin
                            r_state <= S_GAP;
                        end
                    end
                end

                S_GAP: begin
                    if (w_abort) begin
                        err     <= 1'b1;
                        done    <= 1'b1;
                        r_state <= S_FIN;
                    end else if (r_gapcnt == '0) begin
                        auxreq   <= 1'b1;
                        auxaddr  <= r_addr + 20'(r_idx);
                        auxwdata <= r_mem[r_idx[AW-1:0]];
                        r_state  <= S_ISSUE;
                    end else begin
                        r_gapcnt <= r_gapcnt - 1'b1;
                    end
                end

                S_FIN: begin
                    cmdready <= 1'b1;
                    r_state  <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_aux_burst.sv
// =============================================================================
//  Module   : tb_aux_burst
//  Purpose  : Self-checking bench for aux_burst; a scoreboard queue holds each
//             expected engine request and the engine model's reply to it.
//  Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_aux_burst;

    localparam int AW       = 4;
    localparam int MAXRETRY = 7;
    localparam int GAP      = 200;

    logic          clk;
    logic          rst;
    logic          cmdvalid;
    logic          cmdready;
    logic          cmdwr;
    logic [19:0]   cmdaddr;
    logic [AW-1:0] cmdlen;
    logic          bufwe;
    logic [AW-1:0] bufidx;
    logic [7:0]    bufwdata;
    logic [7:0]    bufrdata;
    logic          done;
    logic          err;
    logic [AW:0]   nbytes;
    logic [19:0]   auxaddr;
    logic [7:0]    auxwdata;
    logic          auxreq;
    logic          auxwr;
    logic          auxack;
    logic          auxerr;
    logic [7:0]    auxrdata;

    aux_burst #(.AW(AW), .MAXRETRY(MAXRETRY), .GAP(GAP)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .cmdvalid (cmdvalid),
        .cmdready (cmdready),
        .cmdwr    (cmdwr),
        .cmdaddr  (cmdaddr),
        .cmdlen   (cmdlen),
        .bufwe    (bufwe),
        .bufidx   (bufidx),
        .bufwdata (bufwdata),
        .bufrdata (bufrdata),
        .done     (done),
        .err      (err),
        .nbytes   (nbytes),
        .auxaddr  (auxaddr),
        .auxwdata (auxwdata),
        .auxreq   (auxreq),
        .auxwr    (auxwr),
        .auxack   (auxack),
        .auxerr   (auxerr),
        .auxrdata (auxrdata)
    );

    typedef struct {
        logic [19:0] addr;
        logic        wr;
        logic [7:0]  wdata;
        logic        aerr;
        logic [7:0]  rdata;
        logic        late;
    } req_t;

    req_t sbq[$];
    int   total;
    int   bad;
    int   burst_id;
    int   eng_burst;
    int   idle;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [19:0] a, input logic wr, input logic [7:0] wd,
                        input logic ae, input logic [7:0] rd, input logic late);
        req_t e;
        e.addr = a; e.wr = wr; e.wdata = wd; e.aerr = ae; e.rdata = rd; e.late = late;
        sbq.push_back(e);
    endtask

    // Engine model: replies two cycles after seeing a request.
    task automatic eng_loop();
        req_t        e;
        logic [19:0] a0;
        logic [7:0]  w0;
        logic        wr0;
        forever begin
            @(negedge clk);
            if (!auxreq) begin
                idle++;
            end else if (sbq.size() == 0) begin
                chk("sb_nonempty", 32'(sbq.size()), 1);
                @(negedge clk);
            end else begin
                e = sbq.pop_front();
                chk("req_addr", 32'(auxaddr), 32'(e.addr));
                chk("req_wr", 32'(auxwr), 32'(e.wr));
                if (e.wr) chk("req_wdata", 32'(auxwdata), 32'(e.wdata));
                if (eng_burst == burst_id) chk("gap_len", idle, GAP);
                eng_burst = burst_id;
                a0 = auxaddr; w0 = auxwdata; wr0 = auxwr;
                repeat (2) @(negedge clk);
                if (!e.late)
                    chk("req_stable", {auxreq, wr0, auxaddr, auxwdata, auxwr}, {1'b1, auxwr, a0, w0, wr0});
                auxack = 1'b1; auxerr = e.aerr; auxrdata = e.rdata;
                @(negedge clk);
                auxack = 1'b0; auxerr = 1'b0;
                idle = auxreq ? 0 : 1;
            end
        end
    endtask

    task automatic do_cmd(input logic wr, input logic [19:0] a, input logic [AW-1:0] len);
        burst_id++;
        chk("cmdready_idle", cmdready, 1);
        cmdwr = wr; cmdaddr = a; cmdlen = len; cmdvalid = 1'b1;
        @(negedge clk);
        cmdvalid = 1'b0;
        chk("req_latency", auxreq, 1);
        chk("cmdready_busy", cmdready, 0);
    endtask

    task automatic wait_done(input logic exp_err, input int exp_n);
        int n;
        n = 0;
        while (!done && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", done, 1);
        chk("err", err, 32'(exp_err));
        chk("nbytes", 32'(nbytes), exp_n);
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("cmdready_back", cmdready, 1);
        chk("nbytes_held", 32'(nbytes), exp_n);
    endtask

    task automatic buf_wr(input logic [AW-1:0] i, input logic [7:0] d);
        bufwe = 1'b1; bufidx = i; bufwdata = d;
        @(negedge clk);
        bufwe = 1'b0;
    endtask

    task automatic buf_chk(input string tag, input logic [AW-1:0] i, input logic [7:0] d);
        bufidx = i;
        @(negedge clk);
        chk(tag, 32'(bufrdata), 32'(d));
    endtask

    initial begin
        logic [7:0] rd4 [4];
        logic       seen;
        total = 0; bad = 0; burst_id = 0; eng_burst = -1; idle = 0;
        rst = 1'b1; cmdvalid = 1'b0; cmdwr = 1'b0; cmdaddr = '0; cmdlen = '0;
        bufwe = 1'b0; bufidx = '0; bufwdata = '0;
        auxack = 1'b0; auxerr = 1'b0; auxrdata = '0;
        fork
            eng_loop();
        join_none

        repeat (3) @(negedge clk);
        chk("rst_cmdready", cmdready, 1);
        chk("rst_outs", {done, err, auxreq, auxwr}, 4'b0000);
        chk("rst_nbytes", 32'(nbytes), 0);
        chk("rst_auxaddr", 32'(auxaddr), 0);
        chk("rst_auxwdata", 32'(auxwdata), 0);
        chk("rst_bufrdata", 32'(bufrdata), 0);
        rst = 1'b0;
        @(negedge clk);

        // 4-byte read at address 0
        rd4[0] = 8'h12; rd4[1] = 8'h0A; rd4[2] = 8'h84; rd4[3] = 8'h41;
        for (int i = 0; i < 4; i++) push(20'(i), 1'b0, 8'h00, 1'b0, rd4[i], 1'b0);
        do_cmd(1'b0, 20'h00000, 4'd3);
        wait_done(1'b0, 4);
        for (int i = 0; i < 4; i++) buf_chk("rd4_buf", 4'(i), rd4[i]);

        // 2-byte write at 0x100
        buf_wr(4'd0, 8'h0A);
        buf_wr(4'd1, 8'h84);
        push(20'h00100, 1'b1, 8'h0A, 1'b0, 8'h00, 1'b0);
        push(20'h00101, 1'b1, 8'h84, 1'b0, 8'h00, 1'b0);
        do_cmd(1'b1, 20'h00100, 4'd1);
        wait_done(1'b0, 2);

        // Single-byte read, three errors then success
        for (int i = 0; i < 3; i++) push(20'h00055, 1'b0, 8'h00, 1'b1, 8'hFF, 1'b0);
        push(20'h00055, 1'b0, 8'h00, 1'b0, 8'h5C, 1'b0);
        do_cmd(1'b0, 20'h00055, 4'd0);
        wait_done(1'b0, 1);
        buf_chk("retry_buf", 4'd0, 8'h5C);

        // Single-byte read, every attempt fails
        for (int i = 0; i < MAXRETRY + 1; i++) push(20'h00077, 1'b0, 8'h00, 1'b1, 8'hA5, 1'b0);
        do_cmd(1'b0, 20'h00077, 4'd0);
        wait_done(1'b1, 0);
        repeat (GAP + 50) @(negedge clk);
        chk("exhaust_drained", 32'(sbq.size()), 0);
        chk("exhaust_idle", auxreq, 0);
        buf_chk("exhaust_buf", 4'd0, 8'h5C);

        // Full-depth read wrapping the 20-bit address; busy cmd/bufwe ignored
        for (int i = 0; i < 16; i++)
            push(20'h7FFFE + 20'(i) & 20'hFFFFF | 20'h80000, 1'b0, 8'h00, 1'b0, 8'(i * 7 + 3), 1'b0);
        for (int i = 0; i < 16; i++) sbq[i].addr = 20'hFFFFE + 20'(i);
        do_cmd(1'b0, 20'hFFFFE, 4'd15);
        bufwe = 1'b1; bufidx = 4'd15; bufwdata = 8'hEE;
        cmdvalid = 1'b1; cmdwr = 1'b1; cmdaddr = 20'h33333; cmdlen = 4'd2;
        @(negedge clk);
        bufwe = 1'b0; cmdvalid = 1'b0;
        wait_done(1'b0, 16);
        buf_chk("wrap_buf0", 4'd0, 8'd3);
        buf_chk("wrap_buf15", 4'd15, 8'(15 * 7 + 3));

        // Reset while a request is outstanding, then a late ack
        push(20'h00200, 1'b0, 8'h00, 1'b0, 8'h99, 1'b1);
        do_cmd(1'b0, 20'h00200, 4'd0);
        rst = 1'b1;
        #1;
        chk("rst_mid_req", auxreq, 0);
        chk("rst_mid_ready", cmdready, 1);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            seen = seen | done | auxreq;
        end
        chk("late_ack_ignored", seen, 0);
        chk("late_ack_ready", cmdready, 1);
        chk("late_ack_drained", 32'(sbq.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
